// File: rtl/alu_pkg.sv
// Shared ALU definitions: op code numbering and the width of a response record
// ({data, tag, err}) carried from the ALU stage into the per-requester FIFOs.
package alu_pkg;

   localparam logic [5:0] OP_ADDI  = 6'd0;
   localparam logic [5:0] OP_SLTI  = 6'd1;
   localparam logic [5:0] OP_SLTIU = 6'd2;
   localparam logic [5:0] OP_XORI  = 6'd3;
   localparam logic [5:0] OP_ORI   = 6'd4;
   localparam logic [5:0] OP_ANDI  = 6'd5;
   localparam logic [5:0] OP_SLLI  = 6'd6;
   localparam logic [5:0] OP_SRLI  = 6'd7;
   localparam logic [5:0] OP_SRAI  = 6'd8;
   localparam logic [5:0] OP_ADD   = 6'd9;
   localparam logic [5:0] OP_SUB   = 6'd10;
   localparam logic [5:0] OP_SLL   = 6'd11;
   localparam logic [5:0] OP_SLT   = 6'd12;
   localparam logic [5:0] OP_SLTU  = 6'd13;
   localparam logic [5:0] OP_XOR   = 6'd14;
   localparam logic [5:0] OP_SRL   = 6'd15;
   localparam logic [5:0] OP_SRA   = 6'd16;
   localparam logic [5:0] OP_OR    = 6'd17;
   localparam logic [5:0] OP_AND   = 6'd18;
   localparam logic [5:0] OP_MAX   = OP_AND;

   // Response record width excluding the tag: 32 data bits plus the error flag.
   localparam int RSP_BASE_W = 33;

endpackage

// File: rtl/alu32.sv
// Combinational 32-bit ALU; immediate forms take the immediate on rv2, and all
// shifts use only rv2[4:0].
module alu32
   import alu_pkg::*;
(
   input  logic [5:0]  op,
   input  logic [31:0] rv1,
   input  logic [31:0] rv2,
   output logic [31:0] result
);

   always_comb begin
      result = '0;
      case (op)
         OP_ADDI, OP_ADD:  result = rv1 + rv2;
         OP_SUB:           result = rv1 - rv2;
         OP_SLTI, OP_SLT:  result = {31'b0, $signed(rv1) < $signed(rv2)};
         OP_SLTIU, OP_SLTU: result = {31'b0, rv1 < rv2};
         OP_XORI, OP_XOR:  result = rv1 ^ rv2;
         OP_ORI, OP_OR:    result = rv1 | rv2;
         OP_ANDI, OP_AND:  result = rv1 & rv2;
         OP_SLLI, OP_SLL:  result = rv1 << rv2[4:0];
         OP_SRLI, OP_SRL:  result = rv1 >> rv2[4:0];
         OP_SRAI, OP_SRA:  result = $signed(rv1) >>> rv2[4:0];
         default:          result = '0;
      endcase
   end

endmodule

// File: rtl/alu_rsp_fifo.sv
// Small synchronous FIFO holding ALU responses for one requester; push and pop
// may coincide in any state, including full.
module alu_rsp_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = 37
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;

   function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= bump(wr_ptr);
         if (pop)  rd_ptr <= bump(rd_ptr);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // When full, a simultaneous push overwrites the slot being popped this cycle.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   assign dout  = mem[rd_ptr];
   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/alu_share_arb.sv
// Two requesters share one alu32: round-robin grant with credit-based admission,
// one registered operand stage, then a response FIFO per requester.
module alu_share_arb
   import alu_pkg::*;
#(
   parameter int TAG_W     = 4,
   parameter int RSP_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [1:0]            req_valid,
   output logic [1:0]            req_ready,
   input  logic [1:0][5:0]       req_op,
   input  logic [1:0][31:0]      req_rv1,
   input  logic [1:0][31:0]      req_rv2,
   input  logic [1:0][TAG_W-1:0] req_tag,
   output logic [1:0]            rsp_valid,
   input  logic [1:0]            rsp_ready,
   output logic [1:0][31:0]      rsp_data,
   output logic [1:0][TAG_W-1:0] rsp_tag,
   output logic [1:0]            rsp_err
);

   localparam int RSP_W = RSP_BASE_W + TAG_W;
   localparam int CW    = $clog2(RSP_DEPTH + 1);
   localparam logic [CW-1:0] CMAX = CW'(RSP_DEPTH);

   logic [1:0][CW-1:0]    cnt;
   logic [1:0]            eligible;
   logic [1:0]            push;
   logic [1:0]            pop;
   logic [1:0]            full;
   logic [1:0]            empty;
   logic                  last_grant;
   logic                  s1_valid;
   logic                  s1_owner;
   logic [5:0]            s1_op;
   logic [31:0]           s1_rv1;
   logic [31:0]           s1_rv2;
   logic [TAG_W-1:0]      s1_tag;
   logic [31:0]           alu_result;
   logic                  s1_err;
   logic [RSP_W-1:0]      s1_rsp;
   logic [1:0][RSP_W-1:0] fifo_dout;

   // A credit per outstanding op guarantees FIFO space, so S1 never stalls.
   always_comb begin
      eligible  = '0;
      req_ready = '0;
      for (int i = 0; i < 2; i++) begin
         eligible[i] = req_valid[i] && (cnt[i] < CMAX);
      end
      if (!reset) begin
         if (eligible == 2'b11) req_ready = last_grant ? 2'b01 : 2'b10;
         else                   req_ready = eligible;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid   <= 1'b0;
         last_grant <= 1'b1;
         cnt        <= '0;
      end else begin
         s1_valid <= |req_ready;
         if (|req_ready) begin
            s1_owner   <= req_ready[1];
            s1_op      <= req_op[req_ready[1]];
            s1_rv1     <= req_rv1[req_ready[1]];
            s1_rv2     <= req_rv2[req_ready[1]];
            s1_tag     <= req_tag[req_ready[1]];
            last_grant <= req_ready[1];
         end
         for (int i = 0; i < 2; i++) begin
            cnt[i] <= cnt[i] + CW'(req_ready[i]) - CW'(pop[i]);
         end
      end
   end

   alu32 u_alu (
      .op     (s1_op),
      .rv1    (s1_rv1),
      .rv2    (s1_rv2),
      .result (alu_result)
   );

   // Illegal op codes still complete, returning zero data with the error flag.
   assign s1_err    = (s1_op > OP_MAX);
   assign s1_rsp    = {s1_err ? 32'd0 : alu_result, s1_tag, s1_err};
   assign push      = s1_valid ? (s1_owner ? 2'b10 : 2'b01) : 2'b00;
   assign rsp_valid = ~empty;
   assign pop       = rsp_valid & rsp_ready;

   for (genvar g = 0; g < 2; g++) begin : g_rsp
      alu_rsp_fifo #(
         .DEPTH (RSP_DEPTH),
         .W     (RSP_W)
      ) u_fifo (
         .clk   (clk),
         .reset (reset),
         .push  (push[g]),
         .pop   (pop[g]),
         .din   (s1_rsp),
         .dout  (fifo_dout[g]),
         .full  (full[g]),
         .empty (empty[g])
      );
      assign {rsp_data[g], rsp_tag[g], rsp_err[g]} = fifo_dout[g];
   end

   // Credit accounting must never wrap; a wrap means the admission logic is broken.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < 2; i++) begin
            assert (!(req_ready[i] && !pop[i] && cnt[i] == CMAX));
            assert (!(pop[i] && !req_ready[i] && cnt[i] == '0));
            assert (!(push[i] && full[i] && !pop[i]));
         end
      end
   end

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: directed scenarios followed by random traffic, all
// checked each cycle against a queue-based model of the two response streams.
module tb_alu_share_arb;
   import alu_pkg::*;

   localparam int TAG_W = 4;
   localparam int DEPTH = 2;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [1:0]            req_valid;
   logic [1:0]            req_ready;
   logic [1:0][5:0]       req_op;
   logic [1:0][31:0]      req_rv1;
   logic [1:0][31:0]      req_rv2;
   logic [1:0][TAG_W-1:0] req_tag;
   logic [1:0]            rsp_valid;
   logic [1:0]            rsp_ready;
   logic [1:0][31:0]      rsp_data;
   logic [1:0][TAG_W-1:0] rsp_tag;
   logic [1:0]            rsp_err;

   typedef struct {
      logic [31:0]      data;
      logic [TAG_W-1:0] tag;
      logic             err;
      int               vis;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   logic lastg = 1'b1;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   logic [1:0] obs_rdy;
   logic [1:0] obs_vld;

   always #5 clk = ~clk;

   alu_share_arb #(.TAG_W(TAG_W), .RSP_DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_rv1   (req_rv1),
      .req_rv2   (req_rv2),
      .req_tag   (req_tag),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_tag   (rsp_tag),
      .rsp_err   (rsp_err)
   );

   function automatic logic [31:0] ref_alu(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [4:0] sh;
      sh = b[4:0];
      case (op)
         6'd0, 6'd9:   return a + b;
         6'd10:        return a - b;
         6'd1, 6'd12:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         6'd2, 6'd13:  return (a < b) ? 32'd1 : 32'd0;
         6'd3, 6'd14:  return a ^ b;
         6'd4, 6'd17:  return a | b;
         6'd5, 6'd18:  return a & b;
         6'd6, 6'd11:  return a << sh;
         6'd7, 6'd15:  return a >> sh;
         6'd8, 6'd16:  return $signed(a) >>> sh;
         default:      return 32'd0;
      endcase
   endfunction

   function automatic exp_t make_exp(input int r, input int now);
      exp_t e;
      e.err  = (req_op[r] > 6'd18);
      e.data = e.err ? 32'd0 : ref_alu(req_op[r], req_rv1[r], req_rv2[r]);
      e.tag  = req_tag[r];
      e.vis  = now + 2;
      return e;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s cyc=%0d got=%h want=%h", name, cyc, obs, exp);
      end
   endtask

   task automatic applyStimulus(input int r, input logic [5:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [TAG_W-1:0] tg);
      req_op[r]  = op;
      req_rv1[r] = a;
      req_rv2[r] = b;
      req_tag[r] = tg;
   endtask

   // One clock: check outputs mid-cycle against the model, then advance the model.
   task automatic tick();
      logic [1:0] er;
      logic [1:0] ev;
      logic e0;
      logic e1;
      @(negedge clk);
      er = 2'b00;
      ev = 2'b00;
      e0 = req_valid[0] && (q0.size() < DEPTH);
      e1 = req_valid[1] && (q1.size() < DEPTH);
      if (!reset) begin
         if (e0 && e1) er = lastg ? 2'b01 : 2'b10;
         else          er = {e1, e0};
      end
      if (q0.size() > 0) ev[0] = (q0[0].vis <= cyc);
      if (q1.size() > 0) ev[1] = (q1[0].vis <= cyc);
      checkOutput("req_ready", 32'(req_ready), 32'(er));
      checkOutput("rsp_valid", 32'(rsp_valid), 32'(ev));
      if (ev[0]) begin
         checkOutput("rsp_data0", rsp_data[0], q0[0].data);
         checkOutput("rsp_tag0", 32'(rsp_tag[0]), 32'(q0[0].tag));
         checkOutput("rsp_err0", 32'(rsp_err[0]), 32'(q0[0].err));
      end
      if (ev[1]) begin
         checkOutput("rsp_data1", rsp_data[1], q1[0].data);
         checkOutput("rsp_tag1", 32'(rsp_tag[1]), 32'(q1[0].tag));
         checkOutput("rsp_err1", 32'(rsp_err[1]), 32'(q1[0].err));
      end
      obs_rdy = req_ready;
      obs_vld = rsp_valid;
      if (reset) begin
         q0.delete();
         q1.delete();
         lastg = 1'b1;
      end else begin
         if (ev[0] && rsp_ready[0]) void'(q0.pop_front());
         if (ev[1] && rsp_ready[1]) void'(q1.pop_front());
         if (er[0]) begin q0.push_back(make_exp(0, cyc)); lastg = 1'b0; end
         if (er[1]) begin q1.push_back(make_exp(1, cyc)); lastg = 1'b1; end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic oneOp(input int r, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] tg, input logic [31:0] want, input logic werr, input string name);
      rsp_ready = 2'b11;
      req_valid = 2'b00;
      applyStimulus(r, op, a, b, tg);
      req_valid[r] = 1'b1;
      tick();
      checkOutput({name, "_ready"}, 32'(obs_rdy[r]), 32'd1);
      req_valid = 2'b00;
      tick();
      checkOutput({name, "_valid"}, 32'(rsp_valid[r]), 32'd1);
      checkOutput({name, "_data"}, rsp_data[r], want);
      checkOutput({name, "_tag"}, 32'(rsp_tag[r]), 32'(tg));
      checkOutput({name, "_err"}, 32'(rsp_err[r]), 32'(werr));
      tick();
   endtask

   initial begin
      int g0;
      int g1;
      reset     = 1'b1;
      req_valid = 2'b00;
      rsp_ready = 2'b00;
      for (int i = 0; i < 2; i++) applyStimulus(i, 6'd0, 32'd0, 32'd0, '0);
      @(posedge clk);
      #1;
      tick();
      checkOutput("reset_rsp_valid", 32'(obs_vld), 32'd0);
      reset = 1'b0;
      tick();

      // Single requester, minimum latency.
      oneOp(0, 6'd9, 32'd5, 32'd7, 4'd3, 32'd12, 1'b0, "t1_add");

      // Both requesting SUB every cycle: strict alternation starting with 0.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      rsp_ready = 2'b11;
      req_valid = 2'b11;
      for (int k = 0; k < 10; k++) begin
         for (int i = 0; i < 2; i++)
            applyStimulus(i, 6'd10, $urandom, $urandom, 4'($urandom));
         tick();
         checkOutput("t2_grant", 32'(obs_rdy), (k % 2 == 0) ? 32'd1 : 32'd2);
      end
      req_valid = 2'b00;
      repeat (4) tick();

      // Requester 0 consumer stalled: it receives exactly DEPTH grants.
      rsp_ready = 2'b10;
      req_valid = 2'b11;
      g0 = 0;
      g1 = 0;
      for (int k = 0; k < 10; k++) begin
         for (int i = 0; i < 2; i++)
            applyStimulus(i, 6'($urandom_range(0, 18)), $urandom, $urandom, 4'($urandom));
         tick();
         g0 += int'(obs_rdy[0]);
         g1 += int'(obs_rdy[1]);
      end
      checkOutput("t3_g0", g0, DEPTH);
      checkOutput("t3_g1_some", 32'(g1 > 4), 32'd1);
      rsp_ready = 2'b11;
      g0 = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         g0 += int'(obs_rdy[0]);
      end
      checkOutput("t3_resume", 32'(g0 > 0), 32'd1);
      req_valid = 2'b00;
      repeat (4) tick();

      // Operand-width corner cases and an illegal op.
      oneOp(0, 6'd16, 32'h8000_0000, 32'd4, 4'd1, 32'hF800_0000, 1'b0, "t4_sra");
      oneOp(0, 6'd2, 32'd1, 32'hFFFF_FFFF, 4'd2, 32'd1, 1'b0, "t4_sltiu");
      oneOp(0, 6'd1, 32'd1, 32'hFFFF_FFFF, 4'd4, 32'd0, 1'b0, "t4_slti");
      oneOp(0, 6'd6, 32'd1, 32'd36, 4'd5, 32'h10, 1'b0, "t4_slli");
      oneOp(1, 6'd25, 32'd9, 32'd9, 4'd6, 32'd0, 1'b1, "t5_illegal");
      oneOp(1, 6'd9, 32'd9, 32'd9, 4'd7, 32'd18, 1'b0, "t5_legal");

      // Reset with S1 busy and both FIFOs holding results.
      rsp_ready = 2'b00;
      req_valid = 2'b11;
      repeat (3) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      checkOutput("t6_rsp_valid", 32'(obs_vld), 32'd0);
      checkOutput("t6_tie", 32'(obs_rdy), 32'd1);
      req_valid = 2'b00;
      rsp_ready = 2'b11;
      tick();
      checkOutput("t6_lat", 32'(rsp_valid[0]), 32'd1);
      repeat (3) tick();

      // Random traffic with occasional illegal ops and resets.
      for (int k = 0; k < 500; k++) begin
         req_valid = 2'($urandom);
         rsp_ready = 2'($urandom);
         reset     = ($urandom_range(0, 99) == 0);
         for (int i = 0; i < 2; i++)
            applyStimulus(i, 6'($urandom_range(0, 21)), $urandom,
                          ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom,
                          4'($urandom));
         tick();
      end
      reset     = 1'b0;
      req_valid = 2'b00;
      rsp_ready = 2'b11;
      repeat (6) tick();
      checkOutput("final_empty", 32'(obs_vld), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
